// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID-stage <-> scoreboard signal bundle
//
// Purpose: carries launch reports from ID into the scoreboard and the hazard
// information (per-read-address status, busy/completion masks, WAW flag) back.
// Signals:
//   launch1/launch2, launchN_rd[4:0], launchN_lw : launch reports (ID -> SB)
//   kill                                          : EX redirect, drops launches
//   RAddr1..RAddr4[4:0]                           : ID read addresses
//   stat1..stat4[1:0]                             : 00 ready, 01 forwardable, 10 busy
//   busy_mask[31:0], clr_w_mask[31:0]             : pending / completed writes
//   inflight[5:0], waw_err                        : pending count, sticky WAW flag
// Modports: master = ID side, slave = scoreboard side.
interface reg_scoreboard_if;
    logic        launch1;
    logic [4:0]  launch1_rd;
    logic        launch1_lw;
    logic        launch2;
    logic [4:0]  launch2_rd;
    logic        launch2_lw;
    logic        kill;
    logic [4:0]  RAddr1;
    logic [4:0]  RAddr2;
    logic [4:0]  RAddr3;
    logic [4:0]  RAddr4;
    logic [1:0]  stat1;
    logic [1:0]  stat2;
    logic [1:0]  stat3;
    logic [1:0]  stat4;
    logic [31:0] busy_mask;
    logic [31:0] clr_w_mask;
    logic [5:0]  inflight;
    logic        waw_err;

    modport master (
        output launch1, launch1_rd, launch1_lw,
        output launch2, launch2_rd, launch2_lw,
        output kill, RAddr1, RAddr2, RAddr3, RAddr4,
        input  stat1, stat2, stat3, stat4,
        input  busy_mask, clr_w_mask, inflight, waw_err
    );

    modport slave (
        input  launch1, launch1_rd, launch1_lw,
        input  launch2, launch2_rd, launch2_lw,
        input  kill, RAddr1, RAddr2, RAddr3, RAddr4,
        output stat1, stat2, stat3, stat4,
        output busy_mask, clr_w_mask, inflight, waw_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register-write scoreboard for the dual-issue pipeline
//
// Purpose: tracks every destination register launched by ID, counts each write
// down to its write-back edge, and reports busy/forwarding state back to ID.
// Ports:
//   CLK   : clock, rising-edge
//   RST_N : asynchronous active-low reset
//   sb    : reg_scoreboard_if.slave (launch reports in, hazard status out)
module reg_scoreboard #(
    parameter int CNT_W   = 3,
    parameter int LAT_ALU = 2,
    parameter int LAT_LW  = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    reg_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] LAT_ALU_C = CNT_W'(LAT_ALU);
    localparam logic [CNT_W-1:0] LAT_LW_C  = CNT_W'(LAT_LW);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [31:0]      busy;
    logic [CNT_W-1:0] cnt [32];
    logic [31:0]      clr_q;
    logic             waw_q;

    logic [31:0]      busy_n;
    logic [CNT_W-1:0] cnt_n [32];
    logic [31:0]      clr_n;
    logic             waw_hit;

    logic             eff1;
    logic             eff2;
    logic [CNT_W-1:0] lat1;
    logic [CNT_W-1:0] lat2;
    logic [5:0]       inflight_c;

    assign eff1 = sb.launch1 && !sb.kill && (sb.launch1_rd != 5'd0);
    assign eff2 = sb.launch2 && !sb.kill && (sb.launch2_rd != 5'd0);
    assign lat1 = sb.launch1_lw ? LAT_LW_C : LAT_ALU_C;
    assign lat2 = sb.launch2_lw ? LAT_LW_C : LAT_ALU_C;

    // Register 0 is skipped entirely, so it can never become busy.
    always_comb begin
        busy_n = busy;
        cnt_n  = cnt;
        clr_n  = '0;
        for (int r = 1; r < 32; r++) begin
            if (eff2 && sb.launch2_rd == 5'(r)) begin
                busy_n[r] = 1'b1;
                cnt_n[r]  = lat2;
            end else if (eff1 && sb.launch1_rd == 5'(r)) begin
                busy_n[r] = 1'b1;
                cnt_n[r]  = lat1;
            end else if (busy[r] && cnt[r] == CNT_ONE) begin
                busy_n[r] = 1'b0;
                cnt_n[r]  = '0;
                clr_n[r]  = 1'b1;
            end else if (busy[r] && cnt[r] != '0) begin
                // cnt is >= 2 here, so the decrement cannot wrap.
                cnt_n[r]  = cnt[r] - CNT_ONE;
            end
        end
    end

    // Same-rd dual launch counts as WAW even though instruction 2 simply wins.
    assign waw_hit = (eff1 && busy[sb.launch1_rd]) ||
                     (eff2 && busy[sb.launch2_rd]) ||
                     (eff1 && eff2 && sb.launch1_rd == sb.launch2_rd);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy  <= '0;
            clr_q <= '0;
            waw_q <= 1'b0;
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            busy  <= busy_n;
            cnt   <= cnt_n;
            clr_q <= clr_n;
            waw_q <= waw_q | waw_hit;
        end
    end

    function automatic logic [1:0] stat_of(input logic [4:0] addr);
        if (addr == 5'd0 || !busy[addr]) begin
            return 2'b00;
        end else if (cnt[addr] == CNT_ONE) begin
            return 2'b01;
        end else begin
            return 2'b10;
        end
    endfunction

    always_comb begin
        inflight_c = '0;
        for (int r = 0; r < 32; r++) begin
            inflight_c = inflight_c + 6'(busy[r]);
        end
    end

    assign sb.stat1      = stat_of(sb.RAddr1);
    assign sb.stat2      = stat_of(sb.RAddr2);
    assign sb.stat3      = stat_of(sb.RAddr3);
    assign sb.stat4      = stat_of(sb.RAddr4);
    assign sb.busy_mask  = busy;
    assign sb.clr_w_mask = clr_q;
    assign sb.inflight   = inflight_c;
    assign sb.waw_err    = waw_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    logic CLK;
    logic RST_N;

    reg_scoreboard_if sb_if ();

    reg_scoreboard #(
        .CNT_W   (3),
        .LAT_ALU (2),
        .LAT_LW  (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .sb    (sb_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        l1;
        logic [4:0]  rd1;
        logic        lw1;
        logic        l2;
        logic [4:0]  rd2;
        logic        lw2;
        logic        kill;
        logic [4:0]  ra;
        logic [31:0] e_busy;
        logic [31:0] e_clr;
        logic [1:0]  e_stat;
        logic [5:0]  e_inf;
        logic        e_waw;
    } vec_t;

    int n_total;
    int n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic l1, input logic [4:0] rd1, input logic lw1,
                         input logic l2, input logic [4:0] rd2, input logic lw2,
                         input logic kill);
        sb_if.launch1    = l1;
        sb_if.launch1_rd = rd1;
        sb_if.launch1_lw = lw1;
        sb_if.launch2    = l2;
        sb_if.launch2_rd = rd2;
        sb_if.launch2_lw = lw2;
        sb_if.kill       = kill;
    endtask

    task automatic set_ra(input logic [4:0] ra);
        sb_if.RAddr1 = ra;
        sb_if.RAddr2 = ra;
        sb_if.RAddr3 = ra;
        sb_if.RAddr4 = ra;
    endtask

    task automatic idle;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        idle();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_busy, input logic [31:0] e_clr,
                           input logic [1:0] e_stat, input logic [5:0] e_inf, input logic e_waw);
        chk({tag, " busy_mask"}, sb_if.busy_mask, e_busy);
        chk({tag, " clr_w_mask"}, sb_if.clr_w_mask, e_clr);
        chk({tag, " stat1"}, 32'(sb_if.stat1), 32'(e_stat));
        chk({tag, " stat2"}, 32'(sb_if.stat2), 32'(e_stat));
        chk({tag, " stat3"}, 32'(sb_if.stat3), 32'(e_stat));
        chk({tag, " stat4"}, 32'(sb_if.stat4), 32'(e_stat));
        chk({tag, " inflight"}, 32'(sb_if.inflight), 32'(e_inf));
        chk({tag, " waw_err"}, 32'(sb_if.waw_err), 32'(e_waw));
    endtask

    vec_t vt [15];

    initial begin
        n_total = 0;
        n_pass  = 0;

        // l1 rd1 lw1 l2 rd2 lw2 kill ra | busy clr stat inflight waw
        // rd5 ALU (lat 2): 10, 01, then clear with pulse
        vt[0]  = '{1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 32'h20, 32'h0,  2'b10, 6'd1, 1'b0};
        vt[1]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 32'h20, 32'h0,  2'b01, 6'd1, 1'b0};
        vt[2]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 32'h0,  32'h20, 2'b00, 6'd0, 1'b0};
        vt[3]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 32'h0,  32'h0,  2'b00, 6'd0, 1'b0};
        // rd3 lw (lat 3) + rd4 ALU (lat 2)
        vt[4]  = '{1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd3, 32'h18, 32'h0,  2'b10, 6'd2, 1'b0};
        vt[5]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 32'h18, 32'h0,  2'b10, 6'd2, 1'b0};
        vt[6]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 32'h08, 32'h10, 2'b01, 6'd1, 1'b0};
        vt[7]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 32'h0,  32'h08, 2'b00, 6'd0, 1'b0};
        vt[8]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 32'h0,  32'h0,  2'b00, 6'd0, 1'b0};
        // killed launch, then rd=0 launches on both slots
        vt[9]  = '{1'b1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 32'h0,  32'h0,  2'b00, 6'd0, 1'b0};
        vt[10] = '{1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,  32'h0,  2'b00, 6'd0, 1'b0};
        // both rd7: instruction 2 (ALU) wins, WAW flagged
        vt[11] = '{1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd7, 32'h80, 32'h0,  2'b10, 6'd1, 1'b1};
        vt[12] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 32'h80, 32'h0,  2'b01, 6'd1, 1'b1};
        vt[13] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 32'h0,  32'h80, 2'b00, 6'd0, 1'b1};
        vt[14] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 32'h0,  32'h0,  2'b00, 6'd0, 1'b1};

        set_ra(5'd5);
        RST_N = 1'b1;
        do_reset();
        chk_all("reset", 32'h0, 32'h0, 2'b00, 6'd0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].l1, vt[i].rd1, vt[i].lw1, vt[i].l2, vt[i].rd2, vt[i].lw2, vt[i].kill);
            set_ra(vt[i].ra);
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].e_busy, vt[i].e_clr, vt[i].e_stat,
                    vt[i].e_inf, vt[i].e_waw);
        end
        idle();

        // Launch onto r6 exactly when its count reaches 1: no pulse, fresh count.
        do_reset();
        set_ra(5'd6);
        drive(1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk_all("ovr pre", 32'h40, 32'h0, 2'b01, 6'd1, 1'b0);
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk_all("ovr hit", 32'h40, 32'h0, 2'b10, 6'd1, 1'b1);
        tick();
        chk_all("ovr c2", 32'h40, 32'h0, 2'b10, 6'd1, 1'b1);
        tick();
        chk_all("ovr c1", 32'h40, 32'h0, 2'b01, 6'd1, 1'b1);
        tick();
        chk_all("ovr done", 32'h0, 32'h40, 2'b00, 6'd0, 1'b1);
        tick();
        chk_all("ovr after", 32'h0, 32'h0, 2'b00, 6'd0, 1'b1);

        // Asynchronous reset mid-cycle with r1, r2, r10 pending and a WAW set.
        do_reset();
        set_ra(5'd2);
        drive(1'b1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd10, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
        tick();
        idle();
        chk_all("pre rst", 32'h406, 32'h0, 2'b01, 6'd3, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all("async rst", 32'h0, 32'h0, 2'b00, 6'd0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("post rst%0d", i), 32'h0, 32'h0, 2'b00, 6'd0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
